// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, vld/res_vld pulse handshake.
// Companion of mul_raw; dividend is product-width, divisor is multiplier-width.
module div_seq #(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         vld,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         res_vld,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  dq;
    logic [M-1:0]  dsr;
    logic [M:0]    pr;
    logic [CW-1:0] cnt;

    logic [M:0]    t;
    logic [M:0]    t_sub;
    logic          q_bit;
    logic [M:0]    pr_nxt;
    logic [N-1:0]  dq_nxt;

    // Compare and subtract at M+1 bits so the shifted-in bit is never lost.
    always_comb begin
        t      = {pr[M-1:0], dq[N-1]};
        q_bit  = (t >= {1'b0, dsr});
        t_sub  = t - {1'b0, dsr};
        pr_nxt = q_bit ? t_sub : t;
        dq_nxt = {dq[N-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            dq        <= '0;
            dsr       <= '0;
            pr        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            res_vld   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vld) begin
                        dq    <= dividend;
                        dsr   <= divisor;
                        pr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    dq  <= dq_nxt;
                    pr  <= pr_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // A zero divisor naturally yields all-ones quotient; remainder is forced to 0.
                        state     <= DONE;
                        res_vld   <= 1'b1;
                        quotient  <= dq_nxt;
                        remainder <= (dsr == '0) ? '0 : pr_nxt[M-1:0];
                        div_zero  <= (dsr == '0);
                    end
                end
                DONE: begin
                    res_vld <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes expected results, monitor pops on res_vld.
module tb_div_seq;

    logic        clk;
    logic        rstn;
    logic        vld;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        res_vld;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    div_seq #(.N(16), .M(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .vld       (vld),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .res_vld   (res_vld),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(string name, logic ok, longint act, longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each result pulse, its latency, its width, and output hold between pulses.
    logic        have_last = 1'b0;
    logic        pend_w    = 1'b0;
    logic [15:0] last_q;
    logic [7:0]  last_r;
    logic        last_z;

    always begin
        step();
        if (!rstn) begin
            have_last = 1'b0;
            pend_w    = 1'b0;
        end else begin
            if (pend_w) begin
                check("res_vld_width", !res_vld, res_vld, 0);
                pend_w = 1'b0;
            end else if (res_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_vld", 1'b0, 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("quotient", quotient == e.q, quotient, e.q);
                    check("remainder", remainder == e.r, remainder, e.r);
                    check("div_zero", div_zero == e.dz, div_zero, e.dz);
                    check("latency", cyc == e.acc + 16, cyc - e.acc, 16);
                    if (!e.dz)
                        check("invariant",
                              (32'(quotient) * 32'(e.b) + 32'(remainder) == 32'(e.a)) && (remainder < e.b),
                              32'(quotient) * 32'(e.b) + 32'(remainder), e.a);
                end
                pend_w    = 1'b1;
                have_last = 1'b1;
                last_q    = quotient;
                last_r    = remainder;
                last_z    = div_zero;
            end else if (have_last) begin
                check("hold_stable", quotient == last_q && remainder == last_r && div_zero == last_z,
                      {quotient, remainder, div_zero}, {last_q, last_r, last_z});
            end
        end
    end

    int last_acc;

    task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                        input logic [7:0] r, input logic dz, input logic push);
        int n;
        exp_t e;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) check("busy_timeout", 1'b0, 1, 0);
        vld      = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        last_acc = cyc;
        vld      = 1'b0;
        dividend = $urandom;
        divisor  = 8'($urandom);
        check("busy_after_accept", busy == 1'b1, busy, 1);
        if (push) begin
            e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz; e.acc = last_acc;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        int          c0;
        int          n;

        rstn = 1'b0; vld = 1'b0; dividend = '0; divisor = '0;
        repeat (3) step();
        check("reset_outputs", {busy, res_vld, quotient, remainder, div_zero} == '0,
              {busy, res_vld, quotient, remainder, div_zero}, 0);
        rstn = 1'b1;
        step();

        send(16'd125,  8'd5,  16'd25,  8'd0, 1'b0, 1'b1);
        send(16'd160,  8'd10, 16'd16,  8'd0, 1'b0, 1'b1);
        send(16'd40,   8'd4,  16'd10,  8'd0, 1'b0, 1'b1);
        send(16'd105,  8'd7,  16'd15,  8'd0, 1'b0, 1'b1);
        send(16'd1935, 8'd9,  16'd215, 8'd0, 1'b0, 1'b1);

        send(16'd1937,  8'd9,   16'd215,   8'd2, 1'b0, 1'b1);
        send(16'd7,     8'd200, 16'd0,     8'd7, 1'b0, 1'b1);
        send(16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 1'b1);
        send(16'd65535, 8'd255, 16'd257,   8'd0, 1'b0, 1'b1);

        send(16'd300, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1'b1);
        send(16'd300, 8'd3, 16'd100,  8'd0, 1'b0, 1'b1);

        // Requests while busy (mid-calculation and during DONE) must be dropped.
        send(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b1);
        c0 = last_acc;
        step(); step();
        vld = 1'b1; dividend = 16'd50; divisor = 8'd5;
        step();
        vld = 1'b0;
        while (cyc < c0 + 16) step();
        check("res_vld_in_done", res_vld == 1'b1, res_vld, 1);
        vld = 1'b1; dividend = 16'd50; divisor = 8'd5;
        step();
        vld = 1'b0;
        check("busy_low_at_acc17", busy == 1'b0, busy, 0);
        send(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 1'b1);
        check("next_accept_at_acc18", last_acc == c0 + 18, last_acc - c0, 18);

        // Reset mid-operation aborts without a result.
        send(16'd1000, 8'd10, 16'd100, 8'd0, 1'b0, 1'b0);
        c0 = last_acc;
        while (cyc < c0 + 7) step();
        rstn = 1'b0;
        #1;
        check("abort_outputs_zero", {busy, res_vld, quotient, remainder, div_zero} == '0,
              {busy, res_vld, quotient, remainder, div_zero}, 0);
        step(); step();
        check("abort_outputs_held_zero", {busy, res_vld, quotient, remainder, div_zero} == '0,
              {busy, res_vld, quotient, remainder, div_zero}, 0);
        rstn = 1'b1;
        step();
        send(16'd1000, 8'd10, 16'd100, 8'd0, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = (i % 50 == 0) ? 8'd0 : 8'($urandom);
            if (rb == 8'd0) send(ra, rb, 16'hFFFF, 8'd0, 1'b1, 1'b1);
            else            send(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0, 1'b1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step(); step();
        check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider. It is the inverse companion of the team's mul_raw multiplier: it takes a product-width dividend and a multiplier-width divisor and returns quotient and remainder.
- It uses the same vld / res_vld pulse handshake as mul_raw, so the two blocks can be chained for multiply-then-divide round-trip checks.
- It produces one quotient bit per clock, with fixed latency and no pipelining. One operation is in flight at a time.

Parameters:
- N, 16, dividend and quotient width (matches mul_raw M+N product width).
- M, 8, divisor and remainder width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- vld  input  1  request strobe; dividend/divisor are sampled on the rising edge where vld=1 and busy=0.
- dividend  input  N  unsigned dividend.
- divisor  input  M  unsigned divisor.
- busy  output  1  high while an operation is in progress or its result is being presented; the request is ignored while high.
- res_vld  output  1  one-cycle pulse; quotient, remainder and div_zero are valid while it is high.
- quotient  output  N  unsigned quotient.
- remainder  output  M  unsigned remainder.
- div_zero  output  1  set with res_vld when the captured divisor was 0.

Behaviour:
- Reset (rstn=0, asynchronous):
  - busy, res_vld, quotient, remainder and div_zero all go to 0.
  - The FSM goes to IDLE and the internal registers clear.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - busy=0.
  - On an edge E0 with vld=1, capture dividend into the shift register dq, divisor into dsr, and clear the partial remainder pr (M+1 bits) and bit counter cnt.
  - Go to CALC. busy=1 from E0.
- CALC:
  - Runs one iteration per edge, at edges E0+1 … E0+N.
  - Each iteration:
    - t = {pr[M-1:0], dq[N-1]}.
    - dq shifts left.
    - If t >= {1'b0, dsr}: pr = t - dsr and shift 1 into dq LSB. Otherwise pr = t and shift 0 into dq LSB.
  - On the Nth iteration (cnt=N-1), go to DONE and register the final quotient (dq) and remainder (pr[M-1:0]).
- DONE:
  - res_vld=1 for exactly the one cycle following edge E0+N.
  - At edge E0+N+1: res_vld→0, busy→0, state→IDLE.
- Latency and throughput:
  - res_vld rises N edges after the accept edge.
  - The earliest next accept is edge E0+N+2, giving a throughput of one op per N+2 cycles.
- Output hold: quotient, remainder and div_zero hold their last values after res_vld falls, until the next DONE overwrites them.
- vld while busy=1 (including during DONE) is ignored entirely, with no queuing. Input buses are don't-care except at the accept edge.
- Divisor = 0:
  - Latency is unchanged (the FSM still runs N iterations).
  - Result is quotient = all ones, remainder = 0, div_zero = 1.
  - div_zero is 0 for every nonzero divisor.
- Arithmetic:
  - All unsigned. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor (nonzero divisor).
  - Intermediate compare and subtract use M+1 bits; no truncation is permitted before the compare.
- Reset mid-operation aborts the operation immediately. No res_vld is produced for the aborted op, and outputs read 0.
- cnt is ceil(log2(N))+1 bits wide and must not wrap before N iterations.

Test Plan:
- After rstn release, apply the sequence 125/5, 160/10, 40/4, 105/7, 1935/9, each sent when busy=0.
  - Required quotients: 25, 16, 10, 15, 215, all with remainder 0 and div_zero=0.
  - Each res_vld pulse is 1 cycle wide and arrives exactly 16 edges after its accept edge.
- Boundary values:
  - 1937/9 → q=215, r=2.
  - 7/200 → q=0, r=7.
  - 65535/1 → q=65535, r=0.
  - 65535/255 → q=257, r=0.
- 300/0 → q=16'hFFFF, r=0, div_zero=1, res_vld at accept+16. The next op 300/3 → q=100, div_zero=0.
- Accept 100/7, then pulse vld with 50/5 at accept+3 and again during the DONE cycle.
  - Exactly one result: q=14, r=2.
  - busy low at accept+17; the next accept is possible at accept+18.
- Accept 1000/10, drop rstn at accept+8 for 2 cycles.
  - No res_vld; all outputs 0.
  - After release, 1000/10 → q=100, r=0 with normal latency.
- Random 1000 ops, checked against a reference model by the invariant above. Check also that quotient/remainder stay stable between res_vld pulses.
